// File: rtl/tdm_demux8_if.sv
// Slot-stream and word-handshake signals for the 1:8 TDM demultiplexer.
// slave is the demux side; master is the stream source and word consumer.
interface tdm_demux8_if #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned SEL_W   = 3
);
  logic               en;
  logic               sync;
  logic               din;
  logic               ack;
  logic [SEL_W-1:0]   sel;
  logic [N_SLOTS-1:0] dout;
  logic               valid;
  logic               frame_err;
  logic               overrun;

  modport slave (
    input  en, sync, din, ack,
    output sel, dout, valid, frame_err, overrun
  );

  modport master (
    output en, sync, din, ack,
    input  sel, dout, valid, frame_err, overrun
  );
endinterface

// File: rtl/tdm_demux8.sv
// 1:8 time-division demultiplexer: rebuilds an 8-bit word from a serial slot stream
// and presents it on a valid/ack handshake, flagging misaligned syncs and overruns.
module tdm_demux8 #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned SEL_W   = 3
) (
  input  logic  clk,
  input  logic  rst,
  tdm_demux8_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_SLOTS-1:0] buf_q, buf_d;
  logic [N_SLOTS-1:0] dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic               complete;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    buf_d    = buf_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        StIdle: begin
          if (bus.sync) begin
            buf_d    = '0;
            buf_d[0] = bus.din;
            sel_d    = SEL_W'(1);
            state_d  = StRun;
          end
        end
        StRun: begin
          if (bus.sync && (sel_q != '0)) begin
            // Misaligned sync restarts the frame; the aborted partial never reaches dout.
            buf_d    = '0;
            buf_d[0] = bus.din;
            sel_d    = SEL_W'(1);
            err_d    = 1'b1;
          end else begin
            buf_d[sel_q] = bus.din;
            sel_d        = sel_q + 1'b1;
            complete     = (sel_q == SEL_W'(N_SLOTS - 1));
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (complete) begin
      dout_d  = {bus.din, buf_q[N_SLOTS-2:0]};
      valid_d = 1'b1;
      ovr_d   = valid_q && !bus.ack;
    end else if (bus.ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed frames then random traffic, checked against a
// queue-based model of the slot stream and word handshake.
module tb_tdm_demux8;

  logic clk;
  logic rst;

  tdm_demux8_if bus ();

  tdm_demux8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: bits of the frame in progress, collected in arrival order.
  bit         q[$];
  bit         m_run;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_err;
  logic       m_ovr;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sel"},       {5'd0, bus.sel},       8'(q.size() % 8));
    chk({tag, ".dout"},      bus.dout,              m_dout);
    chk({tag, ".valid"},     {7'd0, bus.valid},     {7'd0, m_valid});
    chk({tag, ".frame_err"}, {7'd0, bus.frame_err}, {7'd0, m_err});
    chk({tag, ".overrun"},   {7'd0, bus.overrun},   {7'd0, m_ovr});
  endtask

  task automatic model_reset();
    q.delete();
    m_run   = 1'b0;
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT just sampled.
  task automatic model_edge(input bit en, input bit sync, input bit din, input bit ack);
    bit         done;
    logic [7:0] word;
    done  = 1'b0;
    word  = 8'h00;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (en) begin
      if (!m_run) begin
        if (sync) begin
          q.delete();
          q.push_back(din);
          m_run = 1'b1;
        end
      end else if (sync && q.size() != 0) begin
        q.delete();
        q.push_back(din);
        m_err = 1'b1;
      end else begin
        q.push_back(din);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) word[i] = q[i];
          q.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      m_ovr   = m_valid && !ack;
      m_dout  = word;
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit en, input bit sync, input bit din, input bit ack,
                      input string tag);
    @(negedge clk);
    bus.en   = en;
    bus.sync = sync;
    bus.din  = din;
    bus.ack  = ack;
    @(posedge clk);
    model_edge(en, sync, din, ack);
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit sync0, input bit ack,
                            input bit gaps, input string tag);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, sync0 && (i == 0), w[i], ack, tag);
      if (gaps && i < 7) step(1'b0, 1'b0, 1'($urandom), ack, {tag, ".gap"});
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = 1'b0;
    bus.ack  = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Aligned frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "t1");
    chk("t1.word", bus.dout, 8'hA5);

    // Second frame without sync while unacknowledged: overrun.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "t2");
    chk("t2.word", bus.dout, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t2.ack");
    chk("t2.cleared", {7'd0, bus.valid}, 8'h00);

    // Misaligned sync at sel=4 aborts 0xFF, then 0x00 completes.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b0, "t3.ff");
    step(1'b1, 1'b1, 1'b0, 1'b0, "t3.resync");
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "t3.zero");
    chk("t3.word", bus.dout, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t3.ack");

    // en toggling between slots.
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, "t4");
    chk("t4.word", bus.dout, 8'h81);

    // Continuous ack across back-to-back frames.
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, "t5a");
    send_frame(8'h34, 1'b0, 1'b1, 1'b0, "t5b");
    chk("t5.word", bus.dout, 8'h34);

    // Async reset mid-frame at sel=5 with a pending word.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, "t6.load");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom), 1'b0, "t6.partial");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("t6.async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, "t6.ignored");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, "t6.restart");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
           $urandom_range(0, 2) == 0, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
